// File: rtl/sonar_varredura_uc.sv
// rtl/sonar_varredura_uc.sv - control unit for a sweeping sonar: measure, transmit frame, wait, move servo
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   ligar             level enable; sampled only in INICIAL and MOVE
//   fim_medida        pulse: distance measurement finished
//   fim_transmissao   pulse: serial character finished
//   medir             pulse: start a distance measurement
//   transmitir        pulse: start sending character sel_char
//   sel_char          index of the character being sent
//   posicao           servo position index 0..7 (triangle sweep)
//   erro_medida       last measurement timed out
//   pronto            pulse: a full step completed
//   db_estado         current state code for debug display
module sonar_varredura_uc #(
  parameter int INTERVALO = 100000000,
  parameter int NUM_CHARS = 8,
  parameter int TIMEOUT   = 2500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       fim_medida,
  input  logic       fim_transmissao,
  output logic       medir,
  output logic       transmitir,
  output logic [2:0] sel_char,
  output logic [2:0] posicao,
  output logic       erro_medida,
  output logic       pronto,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL          = 4'h0,
    PREPARA          = 4'h1,
    MEDE             = 4'h2,
    ESPERA_MEDIDA    = 4'h3,
    TRANSMITE        = 4'h4,
    ESPERA_TX        = 4'h5,
    PROXIMO_CHAR     = 4'h6,
    ESPERA_INTERVALO = 4'h7,
    MOVE             = 4'h8,
    FIM              = 4'hF
  } estado_t;

  localparam logic [31:0] INT_LAST  = 32'(INTERVALO - 1);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT - 1);
  localparam logic [2:0]  CHAR_LAST = 3'(NUM_CHARS - 1);

  estado_t     estado, proximo;
  logic [31:0] cnt_intervalo;
  logic [31:0] cnt_timeout;
  logic        subindo;

  always_ff @(posedge clock) begin
    if (reset) estado <= INICIAL;
    else       estado <= proximo;
  end

  always_comb begin
    proximo = estado;
    case (estado)
      INICIAL:          if (ligar) proximo = PREPARA;
      PREPARA:          proximo = MEDE;
      MEDE:             proximo = ESPERA_MEDIDA;
      // fim_medida wins over a coincident timeout
      ESPERA_MEDIDA:    if (fim_medida || cnt_timeout == TO_LAST) proximo = TRANSMITE;
      TRANSMITE:        proximo = ESPERA_TX;
      ESPERA_TX:        if (fim_transmissao) proximo = PROXIMO_CHAR;
      PROXIMO_CHAR:     proximo = (sel_char == CHAR_LAST) ? ESPERA_INTERVALO : TRANSMITE;
      ESPERA_INTERVALO: if (cnt_intervalo == INT_LAST) proximo = MOVE;
      MOVE:             proximo = ligar ? PREPARA : FIM;
      FIM:              proximo = INICIAL;
      default:          proximo = INICIAL;
    endcase
  end

  // Pulse outputs are decoded from the next state and registered, so each
  // is high exactly during its one-cycle state.
  always_ff @(posedge clock) begin
    if (reset) begin
      medir         <= 1'b0;
      transmitir    <= 1'b0;
      pronto        <= 1'b0;
      erro_medida   <= 1'b0;
      sel_char      <= 3'd0;
      posicao       <= 3'd0;
      subindo       <= 1'b1;
      cnt_intervalo <= 32'd0;
      cnt_timeout   <= 32'd0;
    end else begin
      medir      <= (proximo == MEDE);
      transmitir <= (proximo == TRANSMITE);
      pronto     <= (proximo == MOVE);
      case (estado)
        PREPARA: begin
          sel_char      <= 3'd0;
          cnt_intervalo <= 32'd0;
          cnt_timeout   <= 32'd0;
          erro_medida   <= 1'b0;
        end
        ESPERA_MEDIDA: begin
          if (fim_medida)                 erro_medida <= 1'b0;
          else if (cnt_timeout == TO_LAST) erro_medida <= 1'b1;
          else                            cnt_timeout <= cnt_timeout + 32'd1;
        end
        PROXIMO_CHAR: begin
          if (sel_char != CHAR_LAST) sel_char <= sel_char + 3'd1;
        end
        ESPERA_INTERVALO: begin
          if (cnt_intervalo == INT_LAST) begin
            // posicao changes on MOVE entry so it is valid alongside pronto
            if (subindo) begin
              if (posicao == 3'd7) begin
                subindo <= 1'b0;
                posicao <= 3'd6;
              end else begin
                posicao <= posicao + 3'd1;
              end
            end else begin
              if (posicao == 3'd0) begin
                subindo <= 1'b1;
                posicao <= 3'd1;
              end else begin
                posicao <= posicao - 3'd1;
              end
            end
          end else begin
            cnt_intervalo <= cnt_intervalo + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign db_estado = estado;

endmodule

// File: doc/sonar_varredura_uc.md
SONAR_VARREDURA_UC -- requirements
Module: sonar_varredura_uc

Interface
REQ-001 Parameter INTERVALO, default 100000000, clock cycles of the wait between scan steps (2 s at 50 MHz).
REQ-002 Parameter NUM_CHARS, default 8, number of serial characters sent per step (angle plus distance frame).
REQ-003 Parameter TIMEOUT, default 2500000, maximum cycles spent waiting for fim_medida.
REQ-004 clock  input  1  system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ligar  input  1  level enable; scanning runs while high.
REQ-007 fim_medida  input  1  one-cycle pulse from the sonar datapath: measurement complete.
REQ-008 fim_transmissao  input  1  one-cycle pulse from the serial transmitter: character sent.
REQ-009 medir  output  1  one-cycle pulse starting a distance measurement.
REQ-010 transmitir  output  1  one-cycle pulse starting transmission of character sel_char.
REQ-011 sel_char  output  3  index of the character being transmitted, 0..NUM_CHARS-1.
REQ-012 posicao  output  3  servo position index, 0..7.
REQ-013 erro_medida  output  1  high when the last measurement timed out.
REQ-014 pronto  output  1  one-cycle pulse when a full step (measure, transmit, interval) completes.
REQ-015 db_estado  output  4  current state encoding for debug display.

Function
REQ-016 States and db_estado codes: INICIAL=0, PREPARA=1, MEDE=2, ESPERA_MEDIDA=3, TRANSMITE=4, ESPERA_TX=5, PROXIMO_CHAR=6, ESPERA_INTERVALO=7, MOVE=8, FIM=F.
REQ-017 INICIAL: stay while ligar=0; ligar=1 -> PREPARA.
REQ-018 PREPARA: clear the character counter, interval counter, timeout counter and erro_medida; go to MEDE next cycle.
REQ-019 MEDE: assert medir for exactly one cycle, then ESPERA_MEDIDA.
REQ-020 ESPERA_MEDIDA: fim_medida=1 -> TRANSMITE with erro_medida=0; timeout counter reaching TIMEOUT-1 without fim_medida -> TRANSMITE with erro_medida=1.
REQ-021 TRANSMITE: assert transmitir for one cycle with the current sel_char, then ESPERA_TX.
REQ-022 ESPERA_TX: wait indefinitely for fim_transmissao, then PROXIMO_CHAR.
REQ-023 PROXIMO_CHAR: sel_char=NUM_CHARS-1 -> ESPERA_INTERVALO; otherwise increment sel_char and go to TRANSMITE.
REQ-024 ESPERA_INTERVALO: count INTERVALO cycles, then MOVE.
REQ-025 MOVE: update posicao per REQ-026 and pulse pronto. ligar=1 -> PREPARA; ligar=0 -> FIM.
REQ-026 posicao sweeps 0->7->0 (triangle). Direction up increments. At 7 the direction flips to down and the next value is 6. At 0 the direction flips to up and the next value is 1. posicao never leaves 0..7.
REQ-027 FIM: one cycle, then INICIAL. posicao and direction are retained, so the next ligar resumes the sweep.
REQ-028 ligar falling mid-step does not abort the step; it is sampled only in MOVE and INICIAL.
REQ-029 fim_medida or fim_transmissao arriving outside its wait state is ignored.
REQ-030 medir, transmitir and pronto are registered outputs, never high for two consecutive cycles.
REQ-031 A fim_medida arriving in the same cycle as the timeout is treated as success (erro_medida=0).

Reset
REQ-032 reset=1 at a clock edge forces INICIAL and sets all counters, posicao and sel_char to 0, direction to up, erro_medida/medir/transmitir/pronto to 0, and db_estado to 0, from any state including mid-transmission.

Verification
REQ-033 Use INTERVALO=10, NUM_CHARS=3, TIMEOUT=20 for all scenarios.
REQ-034 Normal step: ligar=1, fim_medida 5 cycles after medir, each fim_transmissao 4 cycles after transmitir -> exactly 1 medir pulse, 3 transmitir pulses with sel_char 0,1,2, erro_medida=0, 10-cycle interval, pronto pulse, posicao 0->1.
REQ-035 Timeout: no fim_medida -> transmitir occurs exactly 20 cycles after the ESPERA_MEDIDA entry, with erro_medida=1 during transmission.
REQ-036 Sweep: 16 consecutive steps -> posicao sequence 1,2,3,4,5,6,7,6,5,4,3,2,1,0,1,2.
REQ-037 Stop: ligar dropped during ESPERA_TX -> the step completes, pronto pulses, FIM then INICIAL; re-asserting ligar resumes from the retained posicao.
REQ-038 Reset mid-operation: reset during ESPERA_TX with sel_char=1 and posicao=5 -> next cycle db_estado=0, posicao=0, sel_char=0, all pulse outputs 0.
REQ-039 Stray pulses: fim_transmissao during ESPERA_INTERVALO and fim_medida during INICIAL -> no state change and no output pulse.
